// File: rtl/bullet_sprite_drawer_pkg.sv
// Shared types and constants for the bullet sprite drawer.
// Screen geometry, field widths, FIFO entry layout and FSM encoding.
package bullet_sprite_drawer_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COLOUR_W     = 3;
    localparam int ENTRY_W      = COLOUR_W + Y_W + X_W;

    localparam int X_LSB        = 0;
    localparam int Y_LSB        = X_LSB + X_W;
    localparam int COLOUR_LSB   = Y_LSB + Y_W;

    // Packed MSB-first, so the layout is {colour, y, x}.
    typedef struct packed {
        logic [COLOUR_W-1:0] colour;
        logic [Y_W-1:0]      y;
        logic [X_W-1:0]      x;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

endpackage

// File: rtl/bullet_sprite_drawer_fifo.sv
// Request FIFO: show-ahead synchronous FIFO of sprite requests.
// Latency: push visible on dout the cycle after the push edge.
// Backpressure: none internally; caller must not push when full without a pop.
module sprite_fifo
    import bullet_sprite_drawer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   empty,
    output logic   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bullet_sprite_drawer.sv
// Expands queued bullet requests into SIZE x SIZE pixel writes for the VGA adapter.
// Latency: first pixel registered two edges after the request is accepted.
// Backpressure: none upstream; requests arriving while the FIFO is full are dropped and flagged.
module bullet_sprite_drawer
    import bullet_sprite_drawer_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                idle,
    output logic                overflow
);
    localparam logic [1:0]   LAST  = 2'(SIZE - 1);
    localparam logic [X_W:0] W_LIM = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] H_LIM = (Y_W + 1)'(SCREEN_H);

    entry_t              fifo_din;
    entry_t              fifo_dout;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;

    state_t              state;
    logic [1:0]          dx;
    logic [1:0]          dy;
    logic [X_W-1:0]      bx;
    logic [Y_W-1:0]      by;
    logic [COLOUR_W-1:0] bc;
    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                last_px;

    // A full FIFO still accepts when the FSM pops on the same edge.
    assign pop      = (state == IDLE) && !fifo_empty;
    assign push     = req_valid && (!fifo_full || pop);
    assign fifo_din = '{colour: req_colour, y: req_y, x: req_x};

    assign px      = {1'b0, bx} + {{(X_W-1){1'b0}}, dx};
    assign py      = {1'b0, by} + {{(Y_W-1){1'b0}}, dy};
    assign last_px = (dx == LAST) && (dy == LAST);

    sprite_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            dx         <= '0;
            dy         <= '0;
            bx         <= '0;
            by         <= '0;
            bc         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            overflow   <= 1'b0;
            idle       <= 1'b1;
        end else begin
            if (req_valid && fifo_full && !pop) overflow <= 1'b1;

            // Pops only happen from IDLE, so the FIFO can only drain when leaving IDLE.
            idle <= ((state == IDLE) || last_px) && fifo_empty && !push;

            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (!fifo_empty) begin
                        bx    <= fifo_dout.x;
                        by    <= fifo_dout.y;
                        bc    <= fifo_dout.colour;
                        dx    <= '0;
                        dy    <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    vga_x      <= px[X_W-1:0];
                    vga_y      <= py[Y_W-1:0];
                    vga_colour <= bc;
                    vga_plot   <= (px < W_LIM) && (py < H_LIM);
                    if (dx == LAST) begin
                        dx <= '0;
                        if (dy == LAST) state <= IDLE;
                        else            dy    <= dy + 2'd1;
                    end else begin
                        dx <= dx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_sprite_drawer.sv
// Self-checking bench for bullet_sprite_drawer: table of single sprites plus burst,
// full-FIFO push/pop and mid-draw reset sequences, checked against a pixel scoreboard.
module tb_bullet_sprite_drawer;
    localparam int SIZE       = 2;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       idle;
    logic       overflow;

    bullet_sprite_drawer #(
        .SIZE       (SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SCREEN_W   (160),
        .SCREEN_H   (120)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .idle       (idle),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int n_plots;
        int delay;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t sb [$];
    int   plot_cycles [$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every plotted pixel must match the oldest expected pixel.
    always @(negedge clk) begin
        pix_t e;
        if (vga_plot === 1'b1) begin
            plot_cycles.push_back(cyc);
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected no plot",
                         vga_x, vga_y, vga_colour);
            end else begin
                e = sb.pop_front();
                if (vga_x == e.x[7:0] && vga_y == e.y[6:0] && vga_colour == e.c[2:0])
                    pass_cnt++;
                else
                    $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int x, input int y, input int c);
        for (int dy = 0; dy < SIZE; dy++)
            for (int dx = 0; dx < SIZE; dx++)
                if (x + dx < 160 && y + dy < 120)
                    sb.push_back('{x + dx, y + dy, c});
    endtask

    // Called at a negedge; returns at the next negedge with acc = the accepting edge.
    task automatic drive_req(input int x, input int y, input int c, output int acc);
        req_x      = 8'(x);
        req_y      = 7'(y);
        req_colour = 3'(c);
        req_valid  = 1'b1;
        acc        = cyc + 1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int at, output int ok);
        int t = 0;
        while (idle !== 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        ok = (idle === 1'b1) ? 1 : 0;
        at = cyc;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t tbl [8];
    int   k;
    int   k0;
    int   at;
    int   ok;
    int   bad;

    initial begin
        tbl[0] = '{10,  20,  4, 4, 2};
        tbl[1] = '{159, 119, 7, 1, 2};
        tbl[2] = '{158, 118, 2, 4, 2};
        tbl[3] = '{159, 5,   3, 2, 2};
        tbl[4] = '{5,   119, 5, 2, 2};
        tbl[5] = '{0,   0,   1, 4, 2};
        tbl[6] = '{160, 0,   6, 0, 0};
        tbl[7] = '{255, 127, 7, 0, 0};

        // Reset held for two edges with a strobe present.
        resetn = 1'b0; req_valid = 1'b1; req_x = 8'd3; req_y = 7'd4; req_colour = 3'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_plot", int'(vga_plot), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_idle", int'(idle), 1);
        resetn = 1'b1; req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_no_draw", plot_cycles.size(), 0);
        check("reset_idle_after", int'(idle), 1);

        // Single sprites, including clipping at the right/bottom edges.
        for (int i = 0; i < 8; i++) begin
            plot_cycles.delete();
            push_exp(tbl[i].x, tbl[i].y, tbl[i].c);
            drive_req(tbl[i].x, tbl[i].y, tbl[i].c, k);
            check("tbl_busy_after_accept", int'(idle), 0);
            wait_idle(50, at, ok);
            check("tbl_idle_timeout", ok, 1);
            check("tbl_idle_cycle", at - k, 1 + SIZE * SIZE);
            repeat (2) @(negedge clk);
            check("tbl_plot_count", plot_cycles.size(), tbl[i].n_plots);
            if (tbl[i].n_plots > 0)
                check("tbl_first_delay", plot_cycles[0] - k, tbl[i].delay);
            check("tbl_sb_empty", sb.size(), 0);
        end

        // Burst of 6 into a 4-deep FIFO: the first pop frees a slot, the 6th drops.
        plot_cycles.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_exp(10 * i, 30, 2);
            drive_req(10 * i, 30, 2, k);
            if (i == 0) k0 = k;
        end
        wait_idle(200, at, ok);
        check("burst_idle_timeout", ok, 1);
        repeat (2) @(negedge clk);
        check("burst_overflow", int'(overflow), 1);
        check("burst_plot_count", plot_cycles.size(), 20);
        check("burst_first_delay", plot_cycles[0] - k0, 2);
        bad = 0;
        for (int i = 1; i < plot_cycles.size(); i++)
            if (plot_cycles[i] - plot_cycles[i-1] != ((i % 4 == 0) ? 2 : 1)) bad++;
        check("burst_gaps", bad, 0);
        check("burst_sb_empty", sb.size(), 0);
        do_reset();
        check("overflow_cleared", int'(overflow), 0);

        // Fill the FIFO, skip one edge, then strobe on the edge the FSM pops.
        plot_cycles.delete();
        for (int i = 0; i < 5; i++) begin
            push_exp(10 * i, 50, 3);
            drive_req(10 * i, 50, 3, k);
        end
        @(negedge clk);
        push_exp(60, 50, 3);
        drive_req(60, 50, 3, k);
        wait_idle(200, at, ok);
        check("pushpop_idle_timeout", ok, 1);
        repeat (2) @(negedge clk);
        check("pushpop_overflow", int'(overflow), 0);
        check("pushpop_plot_count", plot_cycles.size(), 24);
        check("pushpop_sb_empty", sb.size(), 0);

        // Reset during the second pixel of a sprite with two more queued.
        plot_cycles.delete();
        sb.push_back('{70, 60, 6});
        sb.push_back('{71, 60, 6});
        drive_req(70, 60, 6, k0);
        drive_req(80, 60, 6, k);
        drive_req(90, 60, 6, k);
        @(negedge clk);
        check("midreset_second_pixel", int'(vga_plot), 1);
        do_reset();
        check("midreset_plot_low", int'(vga_plot), 0);
        repeat (20) @(negedge clk);
        check("midreset_plot_count", plot_cycles.size(), 2);
        check("midreset_sb_empty", sb.size(), 0);
        check("midreset_idle", int'(idle), 1);
        check("midreset_overflow", int'(overflow), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
